input_conditioner: RTL and testbench

Front-end conditioner for an asynchronous push-button or switch. It synchronises the raw signal into the CLK domain and debounces it with a four-state FSM and a qualification counter. It produces the clean level `x1` and a one-cycle `x1_rise` pulse. It sits directly upstream of the `x1` input of the four-state sequencer, so that block only ever sees a glitch-free, synchronous `x1`.

---
 rtl/input_conditioner.sv | 150 +++++++++++++++
 tb/tb_input_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronises and debounces an asynchronous button into a clean x1 level plus edge pulses.
// Optional feature macro: INPUT_CONDITIONER_SYNC3_EN selects a 3-flop synchroniser (+1 edge latency).
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn_raw,
  output logic x1,
  output logic x1_rise,
  output logic x1_fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             POLARITY = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             r_s;
  logic             s_s;
  logic             sy1_r;
  logic             sy2_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             rise_s;
  logic             fall_s;

  assign r_s = btn_raw ^ POLARITY;

`ifdef INPUT_CONDITIONER_SYNC3_EN
  logic sy3_r;

  // Three-stage synchroniser for fast clocks.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sy1_r <= 1'b0;
      sy2_r <= 1'b0;
      sy3_r <= 1'b0;
    end else begin
      sy1_r <= r_s;
      sy2_r <= sy1_r;
      sy3_r <= sy2_r;
    end
  end

  assign s_s = sy3_r;
`else
  // Two-stage synchroniser.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sy1_r <= 1'b0;
      sy2_r <= 1'b0;
    end else begin
      sy1_r <= r_s;
      sy2_r <= sy1_r;
    end
  end

  assign s_s = sy2_r;
`endif

  // State and qualification counter.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r <= IDLE_LO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state: any return of s to the settled level during WAIT rejects the change.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rise_s      = 1'b0;
    fall_s      = 1'b0;
    case (state_r)
      IDLE_LO: begin
        cnt_nxt_s = CNT_ZERO;
        if (s_s) state_nxt_s = WAIT_HI;
        else     state_nxt_s = IDLE_LO;
      end
      WAIT_HI: begin
        if (!s_s) begin
          state_nxt_s = IDLE_LO;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s = IDLE_HI;
          cnt_nxt_s   = CNT_ZERO;
          rise_s      = 1'b1;
        end else begin
          state_nxt_s = WAIT_HI;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      IDLE_HI: begin
        cnt_nxt_s = CNT_ZERO;
        if (!s_s) state_nxt_s = WAIT_LO;
        else      state_nxt_s = IDLE_HI;
      end
      WAIT_LO: begin
        if (s_s) begin
          state_nxt_s = IDLE_HI;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_nxt_s = IDLE_LO;
          cnt_nxt_s   = CNT_ZERO;
          fall_s      = 1'b1;
        end else begin
          state_nxt_s = WAIT_LO;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LO;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output flops load the decode of the state being entered, so they track state_r exactly.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      x1      <= 1'b0;
      busy    <= 1'b0;
      x1_rise <= 1'b0;
      x1_fall <= 1'b0;
    end else begin
      x1      <= (state_nxt_s == IDLE_HI) || (state_nxt_s == WAIT_LO);
      busy    <= (state_nxt_s == WAIT_HI) || (state_nxt_s == WAIT_LO);
      x1_rise <= rise_s;
      x1_fall <= fall_s;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (DEBOUNCE_CYCLES=4): directed scenarios plus random bounce
// traffic checked against a run-length model of the debouncer on two instances.
module tb_input_conditioner;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic CLR;
  logic btn;
  logic btn_al;
  logic x1, rise, fall, busy;
  logic x1_a, rise_a, fall_a, busy_a;

  int total = 0;
  int bad   = 0;

  // Model per instance (0: active-high, 1: active-low): a 2-deep delay line of r,
  // the accepted level, and the length of the current run of s disagreeing with it.
  logic m_dl0[2];
  logic m_dl1[2];
  logic m_lvl[2];
  logic m_rise[2];
  logic m_fall[2];
  int   m_run[2];

  always #5 CLK = ~CLK;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(0)) dut (
    .CLK(CLK), .CLR(CLR), .btn_raw(btn),
    .x1(x1), .x1_rise(rise), .x1_fall(fall), .busy(busy)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1)) dut_al (
    .CLK(CLK), .CLR(CLR), .btn_raw(btn_al),
    .x1(x1_a), .x1_rise(rise_a), .x1_fall(fall_a), .busy(busy_a)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dl0[i] = 1'b0; m_dl1[i] = 1'b0; m_lvl[i] = 1'b0;
      m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
    end
  endtask

  // Advance n clock edges; a level is accepted once s has disagreed with it for D+1 edges.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      logic rr[2];
      logic cl;
      logic s_pre;
      rr[0] = btn;
      rr[1] = ~btn_al;
      cl    = CLR;
      @(posedge CLK);
      if (cl) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          s_pre     = m_dl1[i];
          m_dl1[i]  = m_dl0[i];
          m_dl0[i]  = rr[i];
          m_rise[i] = 1'b0;
          m_fall[i] = 1'b0;
          if (s_pre != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
              m_lvl[i]  = s_pre;
              m_rise[i] = s_pre;
              m_fall[i] = ~s_pre;
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      #1;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({x1, rise, fall, busy, x1_a, rise_a, fall_a, busy_a} !== 8'h00) begin
      bad++; $display("FAIL reset_state got=%b want=00000000", {x1, rise, fall, busy, x1_a, rise_a, fall_a, busy_a});
    end
    CLR = 1'b0; btn = 1'b1; btn_al = 1'b0;
    tick(8);
    total++;
    if ({x1, x1_a} !== 2'b11) begin bad++; $display("FAIL reset_pre_x1 got=%b want=11", {x1, x1_a}); end
    #2 CLR = 1'b1;
    model_reset();
    #1;
    total++;
    if ({x1, rise, fall, busy, x1_a, rise_a, fall_a, busy_a} !== 8'h00) begin
      bad++; $display("FAIL reset_async got=%b want=00000000", {x1, rise, fall, busy, x1_a, rise_a, fall_a, busy_a});
    end
    @(negedge CLK) CLR = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      total++;
      if (x1 !== (j >= 6) || rise !== (j == 6)) begin
        bad++; $display("FAIL reset_requal j=%0d got x1=%b rise=%b want x1=%b rise=%b", j, x1, rise, j >= 6, j == 6);
      end
    end
  endtask

  task automatic test_release();
    btn = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      total++;
      if (x1 !== (j < 6) || fall !== (j == 6) || busy !== (j >= 2 && j <= 5) || rise !== 1'b0) begin
        bad++; $display("FAIL release j=%0d got x1=%b fall=%b busy=%b rise=%b", j, x1, fall, busy, rise);
      end
    end
  endtask

  task automatic test_clean_press();
    btn = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick(1);
      total++;
      if (x1 !== (j >= 6) || rise !== (j == 6) || busy !== (j >= 2 && j <= 5) || fall !== 1'b0) begin
        bad++; $display("FAIL press j=%0d got x1=%b rise=%b busy=%b fall=%b", j, x1, rise, busy, fall);
      end
    end
  endtask

  task automatic test_bounce();
    int seen_busy;
    seen_busy = 0;
    for (int w = 1; w <= 3; w++) begin
      for (int p = 0; p < w + 2; p++) begin
        btn = (p < w) ? 1'b1 : 1'b0;
        tick(1);
        if (busy === 1'b1) seen_busy++;
        total++;
        if (x1 !== 1'b0 || rise !== 1'b0 || busy !== (m_run[0] > 0) || dut.cnt_r > 3'd2) begin
          bad++; $display("FAIL bounce w=%0d p=%0d got x1=%b rise=%b busy=%b cnt=%0d", w, p, x1, rise, busy, dut.cnt_r);
        end
      end
    end
    btn = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      total++;
      if (x1 !== 1'b0 || rise !== 1'b0) begin bad++; $display("FAIL bounce_tail j=%0d x1=%b rise=%b", j, x1, rise); end
    end
    total++;
    if (seen_busy == 0) begin bad++; $display("FAIL bounce_busy got=0 cycles want>0"); end
  endtask

  task automatic test_reset_mid_wait();
    btn = 1'b1;
    tick(5);
    total++;
    if (busy !== 1'b1 || dut.cnt_r !== 3'd2) begin
      bad++; $display("FAIL midwait_pre got busy=%b cnt=%0d want busy=1 cnt=2", busy, dut.cnt_r);
    end
    #2 CLR = 1'b1;
    model_reset();
    #1;
    total++;
    if (x1 !== 1'b0 || busy !== 1'b0 || dut.cnt_r !== 3'd0) begin
      bad++; $display("FAIL midwait_clr got x1=%b busy=%b cnt=%0d", x1, busy, dut.cnt_r);
    end
    @(negedge CLK) CLR = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      total++;
      if (x1 !== (j >= 6) || rise !== (j == 6)) begin
        bad++; $display("FAIL midwait_requal j=%0d got x1=%b rise=%b", j, x1, rise);
      end
    end
  endtask

  task automatic test_active_low();
    btn_al = 1'b0;
    CLR = 1'b1;
    model_reset();
    @(negedge CLK) CLR = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      total++;
      if (x1_a !== (j >= 6)) begin bad++; $display("FAIL al_x1 j=%0d got=%b want=%b", j, x1_a, j >= 6); end
    end
    btn_al = 1'b1;
    tick(3);
    btn_al = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      total++;
      if (x1_a !== 1'b1 || fall_a !== 1'b0) begin
        bad++; $display("FAIL al_glitch j=%0d got x1=%b fall=%b want x1=1 fall=0", j, x1_a, fall_a);
      end
    end
  endtask

  task automatic test_random();
    int h0, h1;
    h0 = 0; h1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (h0 == 0) begin btn    = 1'($urandom_range(1, 0)); h0 = $urandom_range(8, 1); end
      if (h1 == 0) begin btn_al = 1'($urandom_range(1, 0)); h1 = $urandom_range(8, 1); end
      h0--; h1--;
      tick(1);
      total++;
      if (x1 !== m_lvl[0] || rise !== m_rise[0] || fall !== m_fall[0] || busy !== (m_run[0] > 0) ||
          dut.cnt_r !== 3'((m_run[0] > 0) ? m_run[0] - 1 : 0)) begin
        bad++; $display("FAIL rand0 c=%0d got x1=%b r=%b f=%b b=%b cnt=%0d want x1=%b r=%b f=%b run=%0d",
                        c, x1, rise, fall, busy, dut.cnt_r, m_lvl[0], m_rise[0], m_fall[0], m_run[0]);
      end
      total++;
      if (x1_a !== m_lvl[1] || rise_a !== m_rise[1] || fall_a !== m_fall[1] || busy_a !== (m_run[1] > 0) ||
          (rise_a & fall_a) !== 1'b0) begin
        bad++; $display("FAIL rand1 c=%0d got x1=%b r=%b f=%b b=%b want x1=%b r=%b f=%b run=%0d",
                        c, x1_a, rise_a, fall_a, busy_a, m_lvl[1], m_rise[1], m_fall[1], m_run[1]);
      end
    end
  endtask

  initial begin
    CLR = 1'b1; btn = 1'b0; btn_al = 1'b1;
    model_reset();
    #12;
    test_reset();
    test_release();
    test_bounce();
    test_clean_press();
    test_release();
    test_reset_mid_wait();
    test_active_low();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
